// File: rtl/barrel_if.sv
// Barrel engine bus: launch/abort control, spawn and player geometry,
// platform feedback from the playfield, and the barrel status outputs.
interface barrel_if #(
    parameter int POS_W = 11
);
    logic             launch;
    logic             abort;
    logic [POS_W-1:0] spawn_x;
    logic [POS_W-1:0] spawn_y;
    logic [POS_W-1:0] player_x;
    logic [POS_W-1:0] player_y;
    logic [1:0]       platform;
    logic             end_of_platform;
    logic [POS_W-1:0] landing_y;
    logic             ladder;
    logic             busy;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic             hit;
    logic             done;
    logic [1:0]       done_cause;

    modport master (
        output launch, abort, spawn_x, spawn_y, player_x, player_y,
               platform, end_of_platform, landing_y, ladder,
        input  busy, xpos, ypos, hit, done, done_cause
    );

    modport slave (
        input  launch, abort, spawn_x, spawn_y, player_x, player_y,
               platform, end_of_platform, landing_y, ladder,
        output busy, xpos, ypos, hit, done, done_cause
    );
endinterface

// File: rtl/barrel_engine.sv
// Barrel motion engine: rolls a barrel along sloped platforms, drops it
// off platform ends or down ladders, and retires it on abort, player hit
// or after a fixed number of landings.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no barrel; position outputs hold their last values
// ROLL   | barrel rolls one pixel every STEP_DIV clocks
// FALL   | barrel falls under gravity, one update every GRAV_DIV clocks
module barrel_engine #(
    parameter int POS_W           = 11,
    parameter int STEP_DIV        = 4,
    parameter int GRAV_DIV        = 4,
    parameter int MAX_FALLS       = 3,
    parameter int BARREL_W        = 32,
    parameter int BARREL_H        = 32,
    parameter int PLAYER_W        = 48,
    parameter int PLAYER_H        = 60,
    parameter int PLATFORM_WIDTH  = 32,
    parameter int PLATFORM_OFFSET = 2,
    parameter int LADDER_DROP_EN  = 1
) (
    input logic      clk,
    input logic      rst,
    barrel_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROLL = 2'd1,
        S_FALL = 2'd2
    } state_t;

    localparam int DIV_MAX = (STEP_DIV > GRAV_DIV) ? STEP_DIV : GRAV_DIV;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int FC_W    = $clog2(MAX_FALLS + 1);

    localparam logic [DIV_W-1:0] STEP_TC  = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] GRAV_TC  = DIV_W'(GRAV_DIV - 1);
    localparam logic [FC_W-1:0]  FALL_LIM = FC_W'(MAX_FALLS);
    localparam logic [POS_W-1:0] PLAT_W   = POS_W'(PLATFORM_WIDTH);
    localparam logic [POS_W-1:0] PLAT_OFF = POS_W'(PLATFORM_OFFSET);
    localparam logic [POS_W-1:0] VEL_MAX  = '1;
    localparam logic [POS_W:0]   BAR_W_E  = (POS_W+1)'(BARREL_W);
    localparam logic [POS_W:0]   BAR_H_E  = (POS_W+1)'(BARREL_H);
    localparam logic [POS_W:0]   PLY_W_E  = (POS_W+1)'(PLAYER_W);
    localparam logic [POS_W:0]   PLY_H_E  = (POS_W+1)'(PLAYER_H);

    localparam logic [1:0] CAUSE_FALLS = 2'b00;
    localparam logic [1:0] CAUSE_HIT   = 2'b01;
    localparam logic [1:0] CAUSE_ABORT = 2'b10;

    state_t           state_q, state_d;
    logic [POS_W-1:0] xpos_q, xpos_d;
    logic [POS_W-1:0] ypos_q, ypos_d;
    logic [POS_W-1:0] vel_q, vel_d;
    logic [FC_W-1:0]  fall_cnt_q, fall_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             ladder_used_q, ladder_used_d;
    logic             busy_q, busy_d;
    logic             hit_q, hit_d;
    logic             done_q, done_d;
    logic [1:0]       cause_q, cause_d;

    logic [POS_W-1:0] x_step;
    logic             slope_drop;
    logic [POS_W:0]   y_sum;
    logic [FC_W-1:0]  fall_inc;
    logic             overlap;

    // Candidate roll step, slope drop and gravity sum for this cycle.
    assign x_step     = (bus.platform == 2'b01) ? xpos_q - POS_W'(1) : xpos_q + POS_W'(1);
    assign slope_drop = (bus.platform != 2'b00) && ((x_step % PLAT_W) == '0);
    assign y_sum      = {1'b0, ypos_q} + {1'b0, vel_q};
    assign fall_inc   = fall_cnt_q + FC_W'(1);

    // Box overlap with one extra bit so edge-of-screen sums never wrap.
    assign overlap = ({1'b0, xpos_q} <= {1'b0, bus.player_x} + PLY_W_E) &&
                     ({1'b0, xpos_q} + BAR_W_E >= {1'b0, bus.player_x}) &&
                     ({1'b0, ypos_q} <= {1'b0, bus.player_y} + PLY_H_E) &&
                     ({1'b0, ypos_q} + BAR_H_E >= {1'b0, bus.player_y});

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        xpos_d        = xpos_q;
        ypos_d        = ypos_q;
        vel_d         = vel_q;
        fall_cnt_d    = fall_cnt_q;
        div_d         = div_q;
        hit_d         = 1'b0;
        done_d        = 1'b0;
        cause_d       = cause_q;
        // A drop decision is consumed once per ladder pulse.
        ladder_used_d = bus.ladder & ladder_used_q;
        lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            S_IDLE: begin
                if (bus.launch) begin
                    state_d    = S_ROLL;
                    xpos_d     = bus.spawn_x;
                    ypos_d     = bus.spawn_y;
                    vel_d      = '0;
                    fall_cnt_d = '0;
                    div_d      = '0;
                end
            end
            S_ROLL, S_FALL: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    cause_d = CAUSE_ABORT;
                    div_d   = '0;
                end else if (overlap) begin
                    state_d = S_IDLE;
                    hit_d   = 1'b1;
                    done_d  = 1'b1;
                    cause_d = CAUSE_HIT;
                    div_d   = '0;
                end else if (state_q == S_ROLL) begin
                    if (bus.end_of_platform) begin
                        state_d = S_FALL;
                        vel_d   = '0;
                        div_d   = '0;
                    end else if (div_q == STEP_TC) begin
                        div_d = '0;
                        if ((LADDER_DROP_EN != 0) && bus.ladder && !ladder_used_q && lfsr_q[0]) begin
                            ladder_used_d = 1'b1;
                            state_d       = S_FALL;
                            vel_d         = '0;
                        end else begin
                            if ((LADDER_DROP_EN != 0) && bus.ladder) begin
                                ladder_used_d = 1'b1;
                            end
                            xpos_d = x_step;
                            if (slope_drop) begin
                                ypos_d = ypos_q + PLAT_OFF;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end else begin
                    if (div_q == GRAV_TC) begin
                        div_d = '0;
                        if (y_sum >= {1'b0, bus.landing_y}) begin
                            ypos_d     = bus.landing_y;
                            fall_cnt_d = fall_inc;
                            if (fall_inc == FALL_LIM) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                cause_d = CAUSE_FALLS;
                            end else begin
                                state_d = S_ROLL;
                            end
                        end else begin
                            ypos_d = y_sum[POS_W-1:0];
                            if (vel_q != VEL_MAX) begin
                                vel_d = vel_q + POS_W'(1);
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            xpos_q        <= '0;
            ypos_q        <= '0;
            vel_q         <= '0;
            fall_cnt_q    <= '0;
            div_q         <= '0;
            lfsr_q        <= 8'hA5;
            ladder_used_q <= 1'b0;
            busy_q        <= 1'b0;
            hit_q         <= 1'b0;
            done_q        <= 1'b0;
            cause_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            vel_q         <= vel_d;
            fall_cnt_q    <= fall_cnt_d;
            div_q         <= div_d;
            lfsr_q        <= lfsr_d;
            ladder_used_q <= ladder_used_d;
            busy_q        <= busy_d;
            hit_q         <= hit_d;
            done_q        <= done_d;
            cause_q       <= cause_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.xpos       = xpos_q;
    assign bus.ypos       = ypos_q;
    assign bus.hit        = hit_q;
    assign bus.done       = done_q;
    assign bus.done_cause = cause_q;
endmodule

// File: tb/tb_barrel_engine.sv
// Bench for barrel_engine: directed scenarios plus a randomized run, all
// compared against a behavioural model of the barrel kept in this file.
module tb_barrel_engine;
    localparam int PW   = 11;
    localparam int STEP = 4;
    localparam int GRAV = 1;
    localparam int MAXF = 3;
    localparam int PMAX = 2047;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    barrel_if #(.POS_W(PW)) bus ();

    barrel_engine #(.POS_W(PW), .STEP_DIV(STEP), .GRAV_DIV(GRAV), .MAX_FALLS(MAXF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model of the barrel.
    int m_active = 0, m_fall = 0, m_x = 0, m_y = 0, m_vel = 0, m_falls = 0;
    int m_div = 0, m_lfsr = 165, m_lused = 0, m_hit = 0, m_done = 0, m_cause = 0;

    task automatic model_clk();
        int nl, nx, rc, px, py, nlu;
        bit ov, retire, drop;
        nl = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
        if (!rst) begin
            m_active = 0; m_fall = 0; m_x = 0; m_y = 0; m_vel = 0; m_falls = 0;
            m_div = 0; m_lfsr = 165; m_lused = 0; m_hit = 0; m_done = 0; m_cause = 0;
            return;
        end
        px = int'(bus.player_x);
        py = int'(bus.player_y);
        ov = (m_x <= px + 48) && (m_x + 32 >= px) && (m_y <= py + 60) && (m_y + 32 >= py);
        m_hit = 0; m_done = 0; retire = 0; rc = 0; drop = 0;
        nlu = bus.ladder ? m_lused : 0;
        if (m_active == 0) begin
            if (bus.launch) begin
                m_active = 1; m_fall = 0; m_x = int'(bus.spawn_x); m_y = int'(bus.spawn_y);
                m_vel = 0; m_falls = 0; m_div = 0;
            end
        end else if (bus.abort) begin
            retire = 1; rc = 2;
        end else if (ov) begin
            retire = 1; rc = 1; m_hit = 1;
        end else if (m_fall == 0) begin
            if (bus.end_of_platform) begin
                m_fall = 1; m_vel = 0; m_div = 0;
            end else if (m_div == STEP - 1) begin
                m_div = 0;
                if (bus.ladder && m_lused == 0) begin
                    nlu = 1;
                    drop = (m_lfsr & 1) != 0;
                end
                if (drop) begin
                    m_fall = 1; m_vel = 0;
                end else begin
                    nx = ((bus.platform == 2'b01) ? m_x - 1 : m_x + 1) & PMAX;
                    if (bus.platform != 2'b00 && nx % 32 == 0) m_y = (m_y + 2) & PMAX;
                    m_x = nx;
                end
            end else begin
                m_div++;
            end
        end else begin
            if (m_div == GRAV - 1) begin
                m_div = 0;
                if (m_y + m_vel >= int'(bus.landing_y)) begin
                    m_y = int'(bus.landing_y);
                    m_falls++;
                    if (m_falls == MAXF) begin
                        retire = 1; rc = 0;
                    end else begin
                        m_fall = 0;
                    end
                end else begin
                    m_y = m_y + m_vel;
                    if (m_vel < PMAX) m_vel++;
                end
            end else begin
                m_div++;
            end
        end
        if (retire) begin
            m_active = 0; m_fall = 0; m_done = 1; m_cause = rc; m_div = 0;
        end
        m_lused = nlu;
        m_lfsr = nl;
    endtask

    function automatic logic [26:0] model_vec();
        return {m_active[0], 11'(m_x), 11'(m_y), m_hit[0], m_done[0], 2'(m_cause)};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {bus.busy, bus.xpos, bus.ypos, bus.hit, bus.done, bus.done_cause};
    endfunction

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic quiet_inputs();
        bus.launch = 1'b0; bus.abort = 1'b0; bus.spawn_x = '0; bus.spawn_y = '0;
        bus.player_x = 11'd1500; bus.player_y = 11'd1500; bus.platform = 2'b00;
        bus.end_of_platform = 1'b0; bus.landing_y = 11'd2000; bus.ladder = 1'b0;
    endtask

    task automatic launch_at(input int x, input int y);
        bus.spawn_x = 11'(x); bus.spawn_y = 11'(y); bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        quiet_inputs();
        repeat (3) tick();
        n_checks++;
        if (dut_vec() !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h expected=%h", dut_vec(), 27'd0);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (dut_vec() !== 27'd0) begin
            n_fail++; $display("FAIL reset_idle_hold got=%h expected=%h", dut_vec(), 27'd0);
        end
    endtask

    task automatic test_flat_roll();
        quiet_inputs();
        launch_at(100, 208);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.xpos !== 11'd100 || bus.ypos !== 11'd208) begin
            n_fail++; $display("FAIL flat_launch busy=%b x=%0d y=%0d expected 1 100 208", bus.busy, bus.xpos, bus.ypos);
        end
        repeat (3) tick();
        n_checks++;
        if (bus.xpos !== 11'd100) begin
            n_fail++; $display("FAIL flat_before_step x=%0d expected=100", bus.xpos);
        end
        tick();
        n_checks++;
        if (bus.xpos !== 11'd101) begin
            n_fail++; $display("FAIL flat_first_step x=%0d expected=101", bus.xpos);
        end
        repeat (36) tick();
        n_checks++;
        if (bus.xpos !== 11'd110 || bus.ypos !== 11'd208 || dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL flat_40_clocks x=%0d y=%0d expected 110 208", bus.xpos, bus.ypos);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.done_cause !== 2'b10 || bus.busy !== 1'b0 || bus.hit !== 1'b0) begin
            n_fail++; $display("FAIL flat_abort done=%b cause=%b busy=%b hit=%b expected 1 10 0 0", bus.done, bus.done_cause, bus.busy, bus.hit);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.xpos !== 11'd110) begin
            n_fail++; $display("FAIL flat_after_abort done=%b x=%0d expected 0 110", bus.done, bus.xpos);
        end
    endtask

    task automatic test_slope();
        quiet_inputs();
        bus.platform = 2'b01;
        launch_at(65, 208);
        repeat (4) tick();
        n_checks++;
        if (bus.xpos !== 11'd64 || bus.ypos !== 11'd210) begin
            n_fail++; $display("FAIL slope_first x=%0d y=%0d expected 64 210", bus.xpos, bus.ypos);
        end
        repeat (4 * 31) tick();
        n_checks++;
        if (bus.xpos !== 11'd33 || bus.ypos !== 11'd210) begin
            n_fail++; $display("FAIL slope_mid x=%0d y=%0d expected 33 210", bus.xpos, bus.ypos);
        end
        repeat (4) tick();
        n_checks++;
        if (bus.xpos !== 11'd32 || bus.ypos !== 11'd212) begin
            n_fail++; $display("FAIL slope_second x=%0d y=%0d expected 32 212", bus.xpos, bus.ypos);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_fall_land();
        int exp_y[5] = '{208, 208, 209, 211, 214};
        int k;
        quiet_inputs();
        bus.landing_y = 11'd300;
        launch_at(100, 208);
        bus.end_of_platform = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.ypos !== 11'(exp_y[i]) || bus.xpos !== 11'd100) begin
                n_fail++; $display("FAIL fall_seq_%0d y=%0d x=%0d expected %0d 100", i, bus.ypos, bus.xpos, exp_y[i]);
            end
        end
        k = 0;
        while (bus.done !== 1'b1 && k < 200) begin
            tick();
            k++;
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL fall_model got=%h expected=%h", dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.done_cause !== 2'b00 || bus.ypos !== 11'd300 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL fall_retire done=%b cause=%b y=%0d busy=%b expected 1 00 300 0", bus.done, bus.done_cause, bus.ypos, bus.busy);
        end
        bus.end_of_platform = 1'b0;
    endtask

    task automatic test_hit();
        int k;
        quiet_inputs();
        bus.player_x = 11'd200; bus.player_y = 11'd200;
        launch_at(100, 208);
        k = 0;
        while (bus.done !== 1'b1 && k < 600) begin
            tick();
            k++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.hit !== 1'b1 || bus.done_cause !== 2'b01 || bus.busy !== 1'b0 || bus.xpos !== 11'd168) begin
            n_fail++; $display("FAIL hit_pulse done=%b hit=%b cause=%b busy=%b x=%0d expected 1 1 01 0 168", bus.done, bus.hit, bus.done_cause, bus.busy, bus.xpos);
        end
        tick();
        n_checks++;
        if (bus.hit !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL hit_one_cycle hit=%b done=%b busy=%b expected 0 0 0", bus.hit, bus.done, bus.busy);
        end
    endtask

    task automatic test_abort_launch();
        quiet_inputs();
        bus.player_x = 11'd120; bus.player_y = 11'd200;
        launch_at(100, 208);
        bus.abort = 1'b1;
        tick();
        n_checks++;
        if (bus.done !== 1'b1 || bus.hit !== 1'b0 || bus.done_cause !== 2'b10) begin
            n_fail++; $display("FAIL abort_over_hit done=%b hit=%b cause=%b expected 1 0 10", bus.done, bus.hit, bus.done_cause);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle_ignored done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
        bus.abort = 1'b0;
        bus.player_x = 11'd1500; bus.player_y = 11'd1500;
        launch_at(100, 208);
        bus.launch = 1'b1; bus.spawn_x = 11'd500; bus.spawn_y = 11'd500;
        repeat (8) tick();
        bus.launch = 1'b0;
        n_checks++;
        if (bus.xpos !== 11'd102 || bus.ypos !== 11'd208 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL launch_while_busy x=%0d y=%0d busy=%b expected 102 208 1", bus.xpos, bus.ypos, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        bus.abort = 1'b1; bus.launch = 1'b1;
        bus.spawn_x = 11'd300; bus.spawn_y = 11'd400;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.xpos !== 11'd102) begin
            n_fail++; $display("FAIL retire_cycle_launch done=%b busy=%b x=%0d expected 1 0 102", bus.done, bus.busy, bus.xpos);
        end
        tick();
        bus.launch = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.xpos !== 11'd300 || bus.ypos !== 11'd400 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL relaunch_after_done busy=%b x=%0d y=%0d done=%b expected 1 300 400 0", bus.busy, bus.xpos, bus.ypos, bus.done);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid_fall();
        quiet_inputs();
        bus.landing_y = 11'd1000;
        launch_at(100, 208);
        bus.end_of_platform = 1'b1;
        repeat (6) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (dut_vec() !== 27'd0) begin
            n_fail++; $display("FAIL reset_mid_fall got=%h expected=%h", dut_vec(), 27'd0);
        end
        rst = 1'b1;
        bus.end_of_platform = 1'b0;
        launch_at(100, 208);
        repeat (4) tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.xpos !== 11'd101 || bus.ypos !== 11'd208 || dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL relaunch_fresh busy=%b x=%0d y=%0d expected 1 101 208", bus.busy, bus.xpos, bus.ypos);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_random();
        int ly, shown;
        shown = 0;
        quiet_inputs();
        for (int i = 0; i < 5000; i++) begin
            rst = ($urandom_range(0, 799) != 0);
            bus.launch = ($urandom_range(0, 15) == 0);
            bus.abort = ($urandom_range(0, 299) == 0);
            bus.spawn_x = 11'($urandom_range(0, PMAX));
            bus.spawn_y = 11'($urandom_range(0, 1500));
            if ($urandom_range(0, 49) == 0) bus.platform = 2'($urandom_range(0, 2));
            bus.end_of_platform = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) bus.ladder = ~bus.ladder;
            ly = m_y + int'($urandom_range(0, 80));
            bus.landing_y = 11'((ly > PMAX) ? PMAX : ly);
            if ($urandom_range(0, 399) == 0) begin
                bus.player_x = 11'((m_x + 90 > PMAX) ? PMAX : m_x + 90);
                bus.player_y = 11'(m_y);
            end else if ($urandom_range(0, 99) == 0) begin
                bus.player_x = 11'd1500; bus.player_y = 11'd1500;
            end
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle_%0d got=%h expected=%h", i, dut_vec(), model_vec());
                end
            end
        end
        rst = 1'b1;
        quiet_inputs();
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_flat_roll();
        test_slope();
        test_fall_land();
        test_hit();
        test_abort_launch();
        test_back_to_back();
        test_reset_mid_fall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/barrel_engine.md
BARREL_ENGINE -- requirements
Module: barrel_engine

Interface
REQ-001 Parameters (name, default, meaning): POS_W 11 position width; STEP_DIV 4 clocks per roll step; GRAV_DIV 4 clocks per fall update; MAX_FALLS 3 landings before retirement; BARREL_W 32, BARREL_H 32 barrel box; PLAYER_W 48, PLAYER_H 60 player box; PLATFORM_WIDTH 32 slope segment length; PLATFORM_OFFSET 2 slope drop per segment; LADDER_DROP_EN 1 enables ladder drops.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 launch  in  1  request to spawn a barrel; sampled only in IDLE.
REQ-005 abort  in  1  kill the active barrel.
REQ-006 spawn_x, spawn_y  in  POS_W each  spawn position, sampled on accepted launch.
REQ-007 player_x, player_y  in  POS_W each  player top-left.
REQ-008 platform  in  2  slope under barrel: 00 flat, 01 falls leftward, 10 falls rightward.
REQ-009 end_of_platform  in  1  barrel has run off its platform.
REQ-010 landing_y  in  POS_W  y of next platform below barrel.
REQ-011 ladder  in  1  barrel is centred over a ladder top.
REQ-012 busy  out  1  barrel active (state != IDLE).
REQ-013 xpos, ypos  out  POS_W each  barrel top-left, registered.
REQ-014 hit  out  1  one-cycle pulse, barrel overlapped player.
REQ-015 done  out  1  one-cycle pulse, barrel retired.
REQ-016 done_cause  out  2  valid with done: 00 fall limit, 01 hit, 10 abort.

Function
REQ-017 States IDLE, ROLL, FALL; all outputs registered.
REQ-018 IDLE: launch=1 -> load xpos/ypos from spawn_x/spawn_y, clear counters, go ROLL next cycle; busy rises the same edge.
REQ-019 ROLL: divider counts 0..STEP_DIV-1; on terminal count xpos steps 1 (left if platform==01, else right), divider wraps to 0.
REQ-020 ROLL slope: on a step with platform!=00 and new xpos mod PLATFORM_WIDTH == 0, ypos += PLATFORM_OFFSET in the same step.
REQ-021 ROLL -> FALL when end_of_platform=1; velocity cleared to 0; xpos frozen in FALL.
REQ-022 Ladder drop: LADDER_DROP_EN=1, ladder=1 on a step cycle, LFSR bit0=1 -> FALL; no xpos/ypos change that step; at most one drop decision per ladder rising edge.
REQ-023 LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5 at reset, advances every clock, never zero.
REQ-024 FALL: divider 0..GRAV_DIV-1; on terminal count: if ypos+velocity >= landing_y then ypos=landing_y, fall_cnt+1, return to ROLL; else ypos+=velocity, velocity+1 saturating at 2^POS_W-1.
REQ-025 Landing number MAX_FALLS retires: go IDLE, done=1, done_cause=00.
REQ-026 Overlap: xpos<=player_x+PLAYER_W and xpos+BARREL_W>=player_x and ypos<=player_y+PLAYER_H and ypos+BARREL_H>=player_y; adds POS_W+1 bits wide, no wrap.
REQ-027 Overlap in ROLL or FALL -> hit=1, done=1, done_cause=01, go IDLE next cycle.
REQ-028 abort in ROLL/FALL -> done=1, done_cause=10, go IDLE; abort in IDLE ignored, no pulse.
REQ-029 Same-cycle priority: abort > hit > fall limit > landing > step.
REQ-030 launch while busy ignored, not queued; launch in retiring cycle ignored; accepted earliest one cycle after done.
REQ-031 In IDLE xpos/ypos hold last values; hit/done low except retirement pulses.

Reset
REQ-032 rst=0 at clk edge: state IDLE, xpos=ypos=0, velocity=0, fall_cnt=0, dividers=0, busy=hit=done=0, done_cause=00, LFSR=8'hA5; effective mid-flight, no done pulse.

Verification
REQ-033 Flat roll: platform=00, spawn (100,208), STEP_DIV=4 -> xpos 101 at 4th clock after ROLL entry, 110 after 40 clocks, ypos 208.
REQ-034 Slope: platform=01, spawn x=65 -> at xpos 64 ypos 210; next increment at xpos 32.
REQ-035 Fall/land: end_of_platform at ypos 208, landing_y 300, GRAV_DIV=1 -> ypos 208,209,211,214..., clamps 300, ROLL; third landing -> done, cause 00.
REQ-036 Hit: player (120,200) in path -> one-cycle hit and done, cause 01, busy low next cycle.
REQ-037 Abort+overlap same cycle -> cause 10, no hit; launch during busy -> no effect.
REQ-038 rst=0 mid-FALL -> all outputs zero next edge; relaunch after release behaves as fresh.
